l2_request_scheduler: RTL and testbench
=======================================

L2_REQUEST_SCHEDULER -- requirements
Module: l2_request_scheduler

Interface
REQ-001 SHALL have parameter NUM_PORTS, default L2_NUM_PORTS (2); number of requester ports, power of two, 2..8.
REQ-002 SHALL have parameter SUB_ID_W, default L2_SUB_ID_W; requester sub-ID width.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  in  NUM_PORTS  per-port request pending at head of requester queue.
REQ-006 SHALL have port req_addr  in  NUM_PORTS x 30  per-port word address.
REQ-007 SHALL have ports req_rnw, req_is_amo  in  NUM_PORTS each  per-port read-not-write and atomic flags.
REQ-008 SHALL have port req_amo_type_or_burst_size  in  NUM_PORTS x 5  AMO type, or burst length minus 1.
REQ-009 SHALL have port req_sub_id  in  NUM_PORTS x SUB_ID_W  per-port transaction tag.
REQ-010 SHALL have port req_pop  out  NUM_PORTS  one-hot; dequeues the granted port's request.
REQ-011 SHALL have ports wr_valid  in  NUM_PORTS; wr_data  in  NUM_PORTS x 32; wr_be  in  NUM_PORTS x 4  per-port write-data queue heads.
REQ-012 SHALL have port wr_read  out  NUM_PORTS  dequeues the owner port's write word.
REQ-013 SHALL have ports mem_addr 30, mem_rnw 1, mem_is_amo 1, mem_amo_type_or_burst_size 5, mem_id L2_ID_W, mem_request_valid 1  out  registered request to memory side.
REQ-014 SHALL have port mem_request_pop  in  1  memory side accepts the current request.
REQ-015 SHALL have ports mem_wr_data 32, mem_wr_data_be 4, mem_wr_data_valid 1  out; mem_wr_data_read  in  1.
REQ-016 SHALL have ports mem_rd_id  in  L2_ID_W; mem_rd_data_valid  in  1; rd_valid  out  NUM_PORTS; rd_sub_id  out  SUB_ID_W.

Function
REQ-017 SHALL hold one output request register; it accepts a new grant when empty or when mem_request_pop is high that cycle (one request/cycle throughput).
REQ-018 SHALL register a grant so that req_valid seen at edge t yields mem_request_valid high after edge t+1; req_pop is asserted combinationally in the granting cycle.
REQ-019 SHALL set mem_id = {granted port index, req_sub_id of that port}.
REQ-020 SHALL arbitrate round-robin: the search starts at the port after the last granted port, wrapping from NUM_PORTS-1 to 0.
REQ-021 SHALL classify a request as needing write data iff rnw=0, with beats = 1 if is_amo, else burst_size+1 (1..32).
REQ-022 SHALL implement FSM IDLE/WR_DATA; a write grant in IDLE loads owner = port, beat counter = (is_amo ? 0 : burst_size) and moves to WR_DATA.
REQ-023 SHALL, in WR_DATA, mask write requests from arbitration while still granting reads; masked ports do not advance the round-robin pointer.
REQ-024 SHALL, in WR_DATA, drive mem_wr_data/be/valid from wr_*[owner] and wr_read[owner] = mem_wr_data_read; other wr_read bits stay 0; all are 0 in IDLE.
REQ-025 SHALL decrement the counter on each mem_wr_data_read and return to IDLE on the read with counter = 0; a new write may be granted in that same cycle.
REQ-026 SHALL decode rd_valid[i] = mem_rd_data_valid and (mem_rd_id port field == i), with rd_sub_id = low SUB_ID_W bits of mem_rd_id, combinationally.
REQ-027 SHALL hold mem_* request outputs stable while mem_request_valid=1 and mem_request_pop=0.

Reset
REQ-028 SHALL on rst_n=0 clear mem_request_valid, the FSM (to IDLE), the counter, the owner and the round-robin pointer (port 0 highest priority), asynchronously; all outputs read 0.
REQ-029 SHALL discard any in-flight request and write burst on reset mid-operation; the first grant after release occurs no earlier than the first edge with rst_n=1.

Structure
REQ-030 SHALL take L2_NUM_PORTS, L2_SUB_ID_W and L2_ID_W from package l2_config_and_types.
REQ-031 SHALL implement the round-robin search as sub-module l2_rr_picker (request mask in, one-hot grant and pointer update out).

Verification
REQ-032 Ports 0 and 1 both hold reads continuously, mem_request_pop=1 -> mem_id port fields alternate 0,1,0,1 with one request per cycle.
REQ-033 Port 1 write burst_size=3, then port 0 write -> port 0's write is withheld until the fourth mem_wr_data_read; wr_read[1] pulses exactly 4 times.
REQ-034 During port 1's burst, port 0 issues a read -> the read is granted and wr_read[0] stays 0.
REQ-035 mem_request_pop=0 for 5 cycles with a pending request -> mem_* outputs are unchanged and req_pop stays 0.
REQ-036 mem_rd_data_valid=1, mem_rd_id = {1, sub_id 2} -> rd_valid = 2'b10, rd_sub_id = 2.
REQ-037 rst_n driven low mid-burst (2 of 8 beats done) -> FSM returns to IDLE, all outputs read 0, and the next write is granted normally after reset release.

Source files
------------

// File: rtl/l2_request_scheduler_pkg.sv
// Shared configuration and types for the L2 request scheduler.
//   L2_NUM_PORTS   default number of requester ports
//   L2_SUB_ID_W    width of the per-requester transaction tag
//   L2_PORT_IDX_W  width of the port field carried in a memory ID
//   L2_ID_W        memory-side ID width = {port index, sub-ID}
//   wr_state_e     write-data ownership FSM states
//   l2_wr_beats()  number of write-data words a request carries
package l2_config_and_types;

  localparam int L2_NUM_PORTS  = 2;
  localparam int L2_SUB_ID_W   = 4;
  localparam int L2_PORT_IDX_W = $clog2(L2_NUM_PORTS);
  localparam int L2_ID_W       = L2_PORT_IDX_W + L2_SUB_ID_W;

  typedef enum logic [0:0] {
    WS_IDLE    = 1'b0,
    WS_WR_DATA = 1'b1
  } wr_state_e;

  // Reads carry no data; an AMO write carries one word; a plain write
  // carries burst_size+1 words.
  function automatic logic [5:0] l2_wr_beats(input logic       rnw,
                                             input logic       is_amo,
                                             input logic [4:0] size_m1);
    if (rnw)         return 6'd0;
    else if (is_amo) return 6'd1;
    else             return {1'b0, size_m1} + 6'd1;
  endfunction

endpackage

// File: rtl/l2_rr_picker.sv
// Round-robin picker.
//   req_i      request mask of eligible ports
//   last_i     index of the most recently granted port
//   gnt_o      one-hot grant
//   gnt_idx_o  index of the granted port (the new pointer value)
//   gnt_vld_o  a grant was made
// The search starts at last_i+1 and wraps; NUM_PORTS is a power of two so
// the wrap is the natural overflow of a PIDX_W-bit index.
module l2_rr_picker #(
  parameter int NUM_PORTS = 2,
  localparam int PIDX_W   = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [PIDX_W-1:0]    last_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [PIDX_W-1:0]    gnt_idx_o,
  output logic                 gnt_vld_o
);

  logic [PIDX_W-1:0] idx;

  always_comb begin
    gnt_vld_o = 1'b0;
    gnt_idx_o = '0;
    idx       = '0;
    // k = NUM_PORTS wraps to last_i itself, so the last granted port is
    // considered only after every other port.
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = last_i + PIDX_W'(k);
      if (!gnt_vld_o && req_i[idx]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = idx;
      end
    end
    gnt_o            = '0;
    gnt_o[gnt_idx_o] = gnt_vld_o;
  end

endmodule

// File: rtl/l2_request_scheduler.sv
// L2 request scheduler: arbitrates NUM_PORTS requester queues onto a single
// registered memory request channel, steers the write-data stream of the
// write currently owning the data path, and fans read responses back out.
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_*                          per-port request queue heads
//   req_pop                        one-hot dequeue of the granted request
//   wr_valid/wr_data/wr_be         per-port write-data queue heads
//   wr_read                        dequeue of the owning port's write word
//   mem_* (request)                registered request, mem_request_pop accepts
//   mem_wr_data*                   write-data stream, mem_wr_data_read accepts
//   mem_rd_id/mem_rd_data_valid    read response tag in
//   rd_valid/rd_sub_id             per-port read response strobe and tag
module l2_request_scheduler
  import l2_config_and_types::*;
#(
  parameter int NUM_PORTS = L2_NUM_PORTS,
  parameter int SUB_ID_W  = L2_SUB_ID_W
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_PORTS-1:0]               req_valid,
  input  logic [NUM_PORTS-1:0][29:0]         req_addr,
  input  logic [NUM_PORTS-1:0]               req_rnw,
  input  logic [NUM_PORTS-1:0]               req_is_amo,
  input  logic [NUM_PORTS-1:0][4:0]          req_amo_type_or_burst_size,
  input  logic [NUM_PORTS-1:0][SUB_ID_W-1:0] req_sub_id,
  output logic [NUM_PORTS-1:0]               req_pop,
  input  logic [NUM_PORTS-1:0]               wr_valid,
  input  logic [NUM_PORTS-1:0][31:0]         wr_data,
  input  logic [NUM_PORTS-1:0][3:0]          wr_be,
  output logic [NUM_PORTS-1:0]               wr_read,
  output logic [29:0]                        mem_addr,
  output logic                               mem_rnw,
  output logic                               mem_is_amo,
  output logic [4:0]                         mem_amo_type_or_burst_size,
  output logic [L2_ID_W-1:0]                 mem_id,
  output logic                               mem_request_valid,
  input  logic                               mem_request_pop,
  output logic [31:0]                        mem_wr_data,
  output logic [3:0]                         mem_wr_data_be,
  output logic                               mem_wr_data_valid,
  input  logic                               mem_wr_data_read,
  input  logic [L2_ID_W-1:0]                 mem_rd_id,
  input  logic                               mem_rd_data_valid,
  output logic [NUM_PORTS-1:0]               rd_valid,
  output logic [SUB_ID_W-1:0]                rd_sub_id
);

  localparam int PIDX_W = $clog2(NUM_PORTS);

  // Control state
  logic                mreq_vld_q, mreq_vld_d;
  logic [PIDX_W-1:0]   last_q, last_d;
  wr_state_e           state_q;
  logic [PIDX_W-1:0]   owner_q;
  logic [4:0]          cnt_q;

  // Request payload (only meaningful while mreq_vld_q is set)
  logic [29:0]         maddr_q;
  logic                mrnw_q, mamo_q;
  logic [4:0]          msz_q;
  logic [L2_ID_W-1:0]  mid_q, mid_d;

  logic                wr_last_beat, wr_free, can_accept, wr_grant;
  logic [NUM_PORTS-1:0] elig, gnt;
  logic [PIDX_W-1:0]   gnt_idx;
  logic                gnt_vld;

  // Write requests may only be granted when the write-data path is free or
  // is being released by its final beat in this very cycle.
  assign wr_last_beat = (state_q == WS_WR_DATA) && mem_wr_data_read && (cnt_q == 5'd0);
  assign wr_free      = (state_q == WS_IDLE) || wr_last_beat;
  assign can_accept   = !mreq_vld_q || mem_request_pop;

  // rst_n in the mask keeps req_pop low while reset is held.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      elig[i] = rst_n && can_accept && req_valid[i] && (req_rnw[i] || wr_free);
    end
  end

  l2_rr_picker #(
    .NUM_PORTS (NUM_PORTS)
  ) u_picker (
    .req_i     (elig),
    .last_i    (last_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  assign req_pop  = gnt;
  assign wr_grant = gnt_vld && !req_rnw[gnt_idx];

  always_comb begin
    mid_d                      = '0;
    mid_d[SUB_ID_W +: PIDX_W]  = gnt_idx;
    mid_d[SUB_ID_W-1:0]        = req_sub_id[gnt_idx];
  end

  assign mreq_vld_d = gnt_vld || (mreq_vld_q && !mem_request_pop);
  assign last_d     = gnt_vld ? gnt_idx : last_q;

  // Grant -> memory request register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mreq_vld_q <= 1'b0;
      last_q     <= PIDX_W'(NUM_PORTS - 1);
    end else begin
      mreq_vld_q <= mreq_vld_d;
      last_q     <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (gnt_vld) begin
      maddr_q <= req_addr[gnt_idx];
      mrnw_q  <= req_rnw[gnt_idx];
      mamo_q  <= req_is_amo[gnt_idx];
      msz_q   <= req_amo_type_or_burst_size[gnt_idx];
      mid_q   <= mid_d;
    end
  end

  // Payload reads as zero whenever no request is held, including in reset.
  assign mem_request_valid          = mreq_vld_q;
  assign mem_addr                   = mreq_vld_q ? maddr_q : '0;
  assign mem_rnw                    = mreq_vld_q && mrnw_q;
  assign mem_is_amo                 = mreq_vld_q && mamo_q;
  assign mem_amo_type_or_burst_size = mreq_vld_q ? msz_q : '0;
  assign mem_id                     = mreq_vld_q ? mid_q : '0;

  // Write-data ownership FSM. cnt_q holds beats remaining minus one, so the
  // beat accepted with cnt_q == 0 is the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WS_IDLE;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        WS_IDLE: begin
          if (wr_grant) begin
            owner_q <= gnt_idx;
            cnt_q   <= req_is_amo[gnt_idx] ? 5'd0 : req_amo_type_or_burst_size[gnt_idx];
            state_q <= WS_WR_DATA;
          end
        end
        WS_WR_DATA: begin
          if (mem_wr_data_read) begin
            if (cnt_q == 5'd0) begin
              if (wr_grant) begin
                owner_q <= gnt_idx;
                cnt_q   <= req_is_amo[gnt_idx] ? 5'd0 : req_amo_type_or_burst_size[gnt_idx];
              end else begin
                state_q <= WS_IDLE;
              end
            end else begin
              cnt_q <= cnt_q - 5'd1;
            end
          end
        end
        default: state_q <= WS_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_wr_data       = '0;
    mem_wr_data_be    = '0;
    mem_wr_data_valid = 1'b0;
    wr_read           = '0;
    if (state_q == WS_WR_DATA) begin
      mem_wr_data       = wr_data[owner_q];
      mem_wr_data_be    = wr_be[owner_q];
      mem_wr_data_valid = wr_valid[owner_q];
      wr_read[owner_q]  = mem_wr_data_read;
    end
  end

  // Read response fan-out
  always_comb begin
    rd_valid = '0;
    rd_valid[mem_rd_id[SUB_ID_W +: PIDX_W]] = mem_rd_data_valid;
  end

  assign rd_sub_id = mem_rd_id[SUB_ID_W-1:0];

endmodule

// File: tb/tb_l2_request_scheduler.sv
module tb_l2_request_scheduler;
  import l2_config_and_types::*;

  localparam int NP = L2_NUM_PORTS;
  localparam int SW = L2_SUB_ID_W;
  localparam int IW = L2_ID_W;
  localparam int PW = $clog2(NP);

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [NP-1:0]         req_valid, req_rnw, req_is_amo, req_pop;
  logic [NP-1:0][29:0]   req_addr;
  logic [NP-1:0][4:0]    req_sz;
  logic [NP-1:0][SW-1:0] req_sub_id;
  logic [NP-1:0]         wr_valid, wr_read;
  logic [NP-1:0][31:0]   wr_data;
  logic [NP-1:0][3:0]    wr_be;
  logic [29:0]           mem_addr;
  logic                  mem_rnw, mem_is_amo, mem_request_valid, mem_request_pop;
  logic [4:0]            mem_sz;
  logic [IW-1:0]         mem_id, mem_rd_id;
  logic [31:0]           mem_wr_data;
  logic [3:0]            mem_wr_data_be;
  logic                  mem_wr_data_valid, mem_wr_data_read, mem_rd_data_valid;
  logic [NP-1:0]         rd_valid;
  logic [SW-1:0]         rd_sub_id;

  l2_request_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_rnw(req_rnw), .req_is_amo(req_is_amo),
    .req_amo_type_or_burst_size(req_sz), .req_sub_id(req_sub_id), .req_pop(req_pop),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_be(wr_be), .wr_read(wr_read),
    .mem_addr(mem_addr), .mem_rnw(mem_rnw), .mem_is_amo(mem_is_amo),
    .mem_amo_type_or_burst_size(mem_sz), .mem_id(mem_id),
    .mem_request_valid(mem_request_valid), .mem_request_pop(mem_request_pop),
    .mem_wr_data(mem_wr_data), .mem_wr_data_be(mem_wr_data_be),
    .mem_wr_data_valid(mem_wr_data_valid), .mem_wr_data_read(mem_wr_data_read),
    .mem_rd_id(mem_rd_id), .mem_rd_data_valid(mem_rd_data_valid),
    .rd_valid(rd_valid), .rd_sub_id(rd_sub_id)
  );

  typedef struct packed {
    logic [29:0]   addr;
    logic          rnw;
    logic          amo;
    logic [4:0]    sz;
    logic [SW-1:0] sub;
  } rq_t;

  // Requester-side queues (stimulus) and the reference model state.
  rq_t         rq[NP][$];
  logic [35:0] wd[NP][$];
  int          last;
  bit          m_valid;
  rq_t         m_req;
  int          m_port;
  bit          wa;
  int          wo, wl;
  int          e_gnt;
  bit          e_beat;

  int  enq_pct, pop_pct, beat_pct, rd_pct;
  bit  rand_on;
  int  n_chk, n_fail;
  int  obs[$];
  bit  rec_obs, p33;
  int  cnt1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_req(input int p, input bit rnw, input bit amo, input logic [4:0] sz);
    rq_t r;
    int  n;
    r.addr = 30'($urandom);
    r.rnw  = rnw;
    r.amo  = amo;
    r.sz   = sz;
    r.sub  = SW'($urandom);
    rq[p].push_back(r);
    n = rnw ? 0 : (amo ? 1 : int'(sz) + 1);
    for (int i = 0; i < n; i++) wd[p].push_back(36'({$urandom, $urandom}));
  endtask

  task automatic model_clear();
    for (int p = 0; p < NP; p++) begin
      rq[p].delete();
      wd[p].delete();
    end
    last = NP - 1; m_valid = 0; m_port = 0; m_req = '0;
    wa = 0; wo = 0; wl = 0; e_gnt = -1; e_beat = 0;
  endtask

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      req_valid[p] = rq[p].size() > 0;
      if (req_valid[p]) begin
        req_addr[p] = rq[p][0].addr; req_rnw[p] = rq[p][0].rnw;
        req_is_amo[p] = rq[p][0].amo; req_sz[p] = rq[p][0].sz; req_sub_id[p] = rq[p][0].sub;
      end else begin
        req_addr[p] = 30'($urandom); req_rnw[p] = 1'($urandom); req_is_amo[p] = 1'($urandom);
        req_sz[p] = 5'($urandom); req_sub_id[p] = SW'($urandom);
      end
      wr_valid[p] = wd[p].size() > 0;
      {wr_be[p], wr_data[p]} = wr_valid[p] ? wd[p][0] : 36'($urandom);
    end
    mem_request_pop   = ($urandom % 100) < pop_pct;
    mem_wr_data_read  = wa && (($urandom % 100) < beat_pct);
    mem_rd_data_valid = ($urandom % 100) < rd_pct;
    mem_rd_id         = IW'($urandom);
  endtask

  // Expected behaviour for the current cycle, compared at the falling edge.
  task automatic eval();
    bit            can, blk;
    int            p;
    logic [NP-1:0] exp_pop, exp_wrd, exp_rdv;
    logic [IW-1:0] eid;
    can = !m_valid || mem_request_pop;
    blk = wa && !(mem_wr_data_read && wl == 1);
    e_gnt = -1;
    if (can) begin
      for (int k = 1; k <= NP; k++) begin
        p = (last + k) % NP;
        if (e_gnt < 0 && rq[p].size() > 0 && (rq[p][0].rnw || !blk)) e_gnt = p;
      end
    end
    e_beat  = wa && mem_wr_data_read;
    exp_pop = '0;
    if (e_gnt >= 0) exp_pop[e_gnt] = 1'b1;
    chk("req_pop", 64'(req_pop), 64'(exp_pop));
    chk("mreq_valid", 64'(mem_request_valid), 64'(m_valid));
    eid = '0;
    eid[SW +: PW] = PW'(m_port);
    eid[SW-1:0]   = m_req.sub;
    chk("mreq_fields", 64'({mem_addr, mem_rnw, mem_is_amo, mem_sz, mem_id}),
        m_valid ? 64'({m_req.addr, m_req.rnw, m_req.amo, m_req.sz, eid}) : 64'd0);
    chk("wr_stream", 64'({mem_wr_data_valid, mem_wr_data_be, mem_wr_data}),
        (wa && wd[wo].size() > 0) ? 64'({1'b1, wd[wo][0]}) : 64'd0);
    exp_wrd = '0;
    if (e_beat) exp_wrd[wo] = 1'b1;
    chk("wr_read", 64'(wr_read), 64'(exp_wrd));
    exp_rdv = '0;
    if (mem_rd_data_valid) exp_rdv[int'(mem_rd_id >> SW)] = 1'b1;
    chk("rd_valid", 64'(rd_valid), 64'(exp_rdv));
    chk("rd_sub_id", 64'(rd_sub_id), 64'(int'(mem_rd_id) % (1 << SW)));
    if (rec_obs && mem_request_valid) obs.push_back(int'(mem_id >> SW));
    if (p33) begin
      if (wr_read[1]) cnt1++;
      if (req_pop[0] && !req_rnw[0]) chk("p0_write_held", 64'(cnt1), 64'd4);
      if (req_pop[0] && req_rnw[0]) chk("p0_read_in_burst", 64'(cnt1 < 4), 64'd1);
    end
  endtask

  task automatic update();
    rq_t h;
    int  p;
    if (e_beat) begin
      void'(wd[wo].pop_front());
      wl--;
      if (wl == 0) wa = 0;
    end
    if (e_gnt >= 0) begin
      h = rq[e_gnt].pop_front();
      last = e_gnt; m_valid = 1; m_req = h; m_port = e_gnt;
      if (!h.rnw) begin
        wa = 1; wo = e_gnt; wl = h.amo ? 1 : int'(h.sz) + 1;
      end
    end else if (mem_request_pop) begin
      m_valid = 0;
    end
    if (rand_on && ($urandom % 100) < enq_pct) begin
      p = int'($urandom % NP);
      if (rq[p].size() < 4) begin
        if ($urandom % 2) push_req(p, 1'b1, 1'($urandom), 5'($urandom));
        else              push_req(p, 1'b0, ($urandom % 5) == 0, 5'($urandom % 8));
      end
    end
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    eval();
    @(posedge clk);
    #1;
    update();
  endtask

  task automatic drain(input string tag);
    bit busy;
    busy = 1;
    for (int i = 0; i < 4000 && busy; i++) begin
      busy = wa || m_valid;
      for (int p = 0; p < NP; p++) if (rq[p].size() > 0) busy = 1;
      if (busy) step();
    end
    if (busy) chk({tag, "_drain_timeout"}, 64'd1, 64'd0);
  endtask

  // Assert reset, optionally with a request pending (must not be popped).
  task automatic do_reset(input bit pend, input bit was_bursting);
    rst_n = 1'b0;
    #1;
    if (was_bursting) chk("rst_async_wvld", 64'(mem_wr_data_valid), 64'd0);
    model_clear();
    if (pend) push_req(0, 1'b0, 1'b0, 5'd1);
    drive();
    mem_rd_data_valid = 1'b0;
    mem_wr_data_read  = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_req_pop", 64'(req_pop), 64'd0);
    chk("rst_mreq", 64'({mem_request_valid, mem_addr, mem_rnw, mem_is_amo, mem_sz, mem_id}), 64'd0);
    chk("rst_wr", 64'({mem_wr_data_valid, mem_wr_data_be, mem_wr_data}), 64'd0);
    chk("rst_wr_read", 64'(wr_read), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [29:0] held_addr;
    logic [IW-1:0] held_id;
    n_chk = 0; n_fail = 0;
    rand_on = 0; rec_obs = 0; p33 = 0; cnt1 = 0;
    enq_pct = 0; pop_pct = 100; beat_pct = 100; rd_pct = 0;
    model_clear();
    do_reset(1'b0, 1'b0);

    // Two ports streaming reads: grants alternate, one per cycle.
    for (int i = 0; i < 6; i++) begin
      push_req(0, 1'b1, 1'b0, 5'($urandom));
      push_req(1, 1'b1, 1'b0, 5'($urandom));
    end
    rec_obs = 1;
    for (int i = 0; i < 13; i++) step();
    rec_obs = 0;
    chk("rr_count", 64'(obs.size()), 64'd12);
    for (int i = 0; i < obs.size() && i < 12; i++) chk("rr_alternate", 64'(obs[i]), 64'(i % 2));
    drain("rr");

    // Port 1 burst of 4; port 0 read goes through, port 0 write waits.
    p33 = 1; cnt1 = 0; beat_pct = 50;
    push_req(1, 1'b0, 1'b0, 5'd3);
    step();
    push_req(0, 1'b1, 1'b0, 5'd0);
    push_req(0, 1'b0, 1'b0, 5'd1);
    drain("burst");
    p33 = 0;
    chk("wr1_pulses", 64'(cnt1), 64'd4);
    beat_pct = 100;

    // Back-pressure: request held stable for 5 cycles.
    push_req(0, 1'b1, 1'b1, 5'd9);
    push_req(1, 1'b1, 1'b0, 5'd2);
    step();
    pop_pct = 0;
    held_addr = mem_addr; held_id = mem_id;
    for (int i = 0; i < 5; i++) step();
    chk("hold_addr", 64'(mem_addr), 64'(held_addr));
    chk("hold_id", 64'(mem_id), 64'(held_id));
    pop_pct = 100;
    drain("hold");

    // Read response decode for {port 1, sub 2}.
    mem_rd_data_valid = 1'b1;
    mem_rd_id = IW'((1 << SW) | 2);
    #1;
    chk("rd_dec_valid", 64'(rd_valid), 64'(2'b10));
    chk("rd_dec_sub", 64'(rd_sub_id), 64'd2);
    mem_rd_data_valid = 1'b0;

    // Reset two beats into an eight-beat burst, then a fresh write.
    push_req(0, 1'b0, 1'b0, 5'd7);
    for (int i = 0; i < 30 && !(wa && wl == 6); i++) step();
    chk("burst_progress", 64'(wl), 64'd6);
    do_reset(1'b1, 1'b1);
    drain("post_reset");

    // Randomised traffic.
    rand_on = 1; enq_pct = 60; pop_pct = 70; beat_pct = 70; rd_pct = 30;
    for (int i = 0; i < 3000; i++) step();
    rand_on = 0;
    drain("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
